// File: rtl/bsg_profiler_counter_bank_pkg.sv
// Shared types for the profiler counter bank.
package bsg_profiler_counter_bank_pkg;

  typedef enum logic [0:0] {e_pcb_idle, e_pcb_dump} bsg_pcb_state_e;

endpackage

// File: rtl/bsg_profiler_counter_sat.sv
// One profiler lane: enabled multi-bit increment, saturating or wrapping,
// with a sticky overflow flag and a clear that keeps the current cycle's event.
module bsg_profiler_counter_sat
  import bsg_profiler_counter_bank_pkg::*;
#(
  parameter int width_p     = 32,
  parameter int inc_width_p = 4,
  parameter int saturate_p  = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic [inc_width_p-1:0] inc_i,
  input  logic                   clear_i,
  output logic [width_p-1:0]     count_o,
  output logic                   ovf_o
);

  logic [width_p-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [width_p-1:0] inc_masked;
  logic [width_p:0]   sum;

  // Next count: a clear restarts from this cycle's increment, otherwise add with carry-out.
  always_comb begin
    inc_masked = '0;
    if (en_i) begin
      inc_masked[inc_width_p-1:0] = inc_i;
    end else begin
      inc_masked = '0;
    end
    sum   = {1'b0, cnt_q} + {1'b0, inc_masked};
    cnt_d = sum[width_p-1:0];
    ovf_d = ovf_q;
    if (clear_i) begin
      cnt_d = inc_masked;
      ovf_d = 1'b0;
    end else if (sum[width_p]) begin
      ovf_d = 1'b1;
      if (saturate_p != 0) begin
        cnt_d = '1;
      end else begin
        cnt_d = sum[width_p-1:0];
      end
    end else begin
      cnt_d = sum[width_p-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/bsg_profiler_counter_bank.sv
// Multi-channel event counter bank with atomic snapshot and serial valid/yumi drain.
// Define BSG_PROFILER_COUNTER_BANK_SKIP_ZERO_EN to drain only nonzero/overflowed channels.
module bsg_profiler_counter_bank
  import bsg_profiler_counter_bank_pkg::*;
#(
  parameter int els_p       = 8,
  parameter int width_p     = 32,
  parameter int inc_width_p = 4,
  parameter int saturate_p  = 1,
  localparam int lg_els_lp  = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [els_p*inc_width_p-1:0] inc_i,
  input  logic [els_p-1:0]             en_i,
  input  logic                         snap_v_i,
  input  logic                         clear_on_snap_i,
  output logic                         snap_ready_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  output logic [lg_els_lp-1:0]         id_o,
  output logic                         ovf_o,
  input  logic                         yumi_i,
  output logic [els_p-1:0]             live_ovf_o
);

  bsg_pcb_state_e       state_q, state_d;
  logic [lg_els_lp-1:0] idx_q, idx_d;
  logic [width_p-1:0]   cnt      [els_p];
  logic [els_p-1:0]     live_ovf;
  logic [width_p-1:0]   shadow_q [els_p];
  logic [els_p-1:0]     shadow_ovf_q;
  logic                 snap_accept;
  logic                 found;
  logic                 more;
  logic [lg_els_lp-1:0] cur;

  assign snap_accept = ~reset_i & snap_v_i & (state_q == e_pcb_idle);

  for (genvar k = 0; k < els_p; k++) begin : g_lane
    bsg_profiler_counter_sat #(
      .width_p    (width_p),
      .inc_width_p(inc_width_p),
      .saturate_p (saturate_p)
    ) lane (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .en_i   (en_i[k]),
      .inc_i  (inc_i[k*inc_width_p +: inc_width_p]),
      .clear_i(snap_accept & clear_on_snap_i),
      .count_o(cnt[k]),
      .ovf_o  (live_ovf[k])
    );
  end

  // Shadow copy takes the pre-edge live values, before this cycle's increment.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < els_p; k++) begin
        shadow_q[k] <= '0;
      end
      shadow_ovf_q <= '0;
    end else if (snap_accept) begin
      for (int k = 0; k < els_p; k++) begin
        shadow_q[k] <= cnt[k];
      end
      shadow_ovf_q <= live_ovf;
    end else begin
      shadow_ovf_q <= shadow_ovf_q;
    end
  end

`ifdef BSG_PROFILER_COUNTER_BANK_SKIP_ZERO_EN
  // Lowest qualifying channel at or above idx_q, and whether another follows it.
  always_comb begin
    found = 1'b0;
    more  = 1'b0;
    cur   = '0;
    for (int k = 0; k < els_p; k++) begin
      if ((k >= int'(idx_q)) && ((shadow_q[k] != '0) || shadow_ovf_q[k])) begin
        if (found) begin
          more = 1'b1;
        end else begin
          found = 1'b1;
          cur   = lg_els_lp'(k);
        end
      end else begin
        more = more;
      end
    end
  end
`else
  assign found = 1'b1;
  assign cur   = idx_q;
  assign more  = (idx_q != lg_els_lp'(els_p - 1));
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_pcb_idle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      e_pcb_idle: begin
        if (snap_accept) begin
          state_d = e_pcb_dump;
          idx_d   = '0;
        end else begin
          state_d = e_pcb_idle;
        end
      end
      e_pcb_dump: begin
        if (!found) begin
          state_d = e_pcb_idle;
        end else if (yumi_i) begin
          if (more) begin
            idx_d = cur + lg_els_lp'(1);
          end else begin
            state_d = e_pcb_idle;
          end
        end else begin
          state_d = e_pcb_dump;
        end
      end
      default: begin
        state_d = e_pcb_idle;
        idx_d   = '0;
      end
    endcase
  end

  // Every output is forced low while reset_i is asserted.
  always_comb begin
    snap_ready_o = 1'b0;
    v_o          = 1'b0;
    data_o       = '0;
    id_o         = '0;
    ovf_o        = 1'b0;
    live_ovf_o   = '0;
    if (reset_i) begin
      live_ovf_o = '0;
    end else begin
      live_ovf_o = live_ovf;
      case (state_q)
        e_pcb_idle: snap_ready_o = 1'b1;
        e_pcb_dump: begin
          if (found) begin
            v_o    = 1'b1;
            data_o = shadow_q[cur];
            id_o   = cur;
            ovf_o  = shadow_ovf_q[cur];
          end else begin
            v_o = 1'b0;
          end
        end
        default: snap_ready_o = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/bsg_profiler_counter_bank.md
Name: bsg_profiler_counter_bank

Overview:
- Synthesizable, multi-channel event-counter bank; successor to the per-instance nonsynth conditional-increment profiler clients.
- Each channel adds a multi-bit increment per cycle when its condition enable is high.
- Saturating or wrapping counters, sticky overflow.
- Atomic snapshot (optional clear) of all channels, then serial drain over a valid/yumi handshake for on-chip profiling readout.

Parameters:
- els_p, 8: number of channels (>=1).
- width_p, 32: counter width per channel.
- inc_width_p, 4: per-channel increment width per cycle.
- saturate_p, 1: 1 = counters stick at all-ones; 0 = counters wrap modulo 2^width_p.
- lg_els_lp, `BSG_SAFE_CLOG2(els_p): localparam, channel index width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- inc_i  in  els_p*inc_width_p  per-channel increment amount; channel k occupies bits [k*inc_width_p +: inc_width_p].
- en_i  in  els_p  per-channel count condition.
- snap_v_i  in  1  snapshot request.
- clear_on_snap_i  in  1  zero live counters and overflow flags on an accepted snapshot.
- snap_ready_o  out  1  high in IDLE; snapshot is accepted when snap_v_i & snap_ready_o.
- v_o  out  1  drain data valid.
- data_o  out  width_p  snapshotted count.
- id_o  out  lg_els_lp  channel index of data_o.
- ovf_o  out  1  snapshotted overflow flag of channel id_o.
- yumi_i  in  1  consumer takes data_o; legal only when v_o is high.
- live_ovf_o  out  els_p  live sticky overflow flags.

Behaviour:
- Reset (synchronous, reset_i=1 at the edge):
  - All live counters, shadow registers, overflow flags and the drain index go to 0; FSM goes to IDLE.
  - Outputs while in reset: snap_ready_o=0, v_o=0, data_o=0, id_o=0, ovf_o=0, live_ovf_o=0.
  - Reset during DUMP abandons the drain; no further v_o.
- Counting, every cycle, channel k:
  - sum = cnt[k] + (en_i[k] ? inc_k : 0), computed at width_p+1 bits.
  - If sum[width_p]=1: live_ovf[k] <= 1 (sticky). cnt[k] <= all-ones when saturate_p=1, otherwise the low width_p bits.
  - en_i[k]=0 or inc_k=0 leaves cnt[k] unchanged.
  - Counting continues in both FSM states.
- Snapshot, on the edge where snap_v_i & snap_ready_o:
  - shadow[k] <= cnt[k] and shadow_ovf[k] <= live_ovf[k]: the pre-edge values, excluding this cycle's increment.
  - If clear_on_snap_i=1: cnt[k] <= this cycle's masked increment (no event lost) and live_ovf[k] <= 0. An increment that itself overflows cannot occur after a clear, since inc_width_p <= width_p is required.
  - If clear_on_snap_i=0: cnt[k] updates normally.
  - Index <= 0; FSM -> DUMP.
- FSM:
  - IDLE: snap_ready_o=1, v_o=0. Goes to DUMP on an accepted snapshot.
  - DUMP: snap_ready_o=0, v_o=1, data_o=shadow[idx], id_o=idx, ovf_o=shadow_ovf[idx].
    - yumi_i & idx<els_p-1: idx++.
    - yumi_i & idx==els_p-1: go to IDLE.
    - No yumi: outputs held stable.
  - Snapshot-to-first-v_o latency: 1 cycle.
  - A new snapshot can be accepted the cycle after the last yumi.
  - snap_v_i in DUMP is ignored; the requester must hold it.
- els_p=1: DUMP lasts until a single yumi.
- Outside DUMP, data_o, id_o and ovf_o are 0.

Optional Feature:
- Macro: BSG_PROFILER_COUNTER_BANK_SKIP_ZERO_EN.
- Defined:
  - DUMP presents only channels whose shadow value is nonzero or whose shadow_ovf is set.
  - On entry and after each yumi, idx advances to the next such channel in ascending order via a priority encoder.
  - If no qualifying channel remains, the FSM returns to IDLE with v_o low.
  - An all-zero snapshot costs one DUMP cycle with v_o=0.
- Undefined: every channel 0..els_p-1 is emitted, as described above.

Decomposition:
- Package bsg_profiler_counter_bank_pkg:
  - typedef enum logic [0:0] {e_pcb_idle, e_pcb_dump} bsg_pcb_state_e.
  - No other shared constants.
- Sub-module bsg_profiler_counter_sat: one channel lane (width_p, inc_width_p, saturate_p; inputs en, inc, clear; outputs count, sticky ovf), instantiated els_p times.
- The FSM and shadow registers live in the top module.

Test Plan:
- Basic count: els_p=8, width_p=32; channel 3 gets en=1, inc=5 for 10 cycles, all other channels en=0. Snapshot with clear=0, yumi every cycle -> ids 0..7 in order, data for id 3 = 50, all others 0, all ovf=0.
- Saturation: width_p=8, saturate_p=1; preload channel 0 to 250, then inc=15 once -> live count 255, live_ovf_o[0]=1. A further inc=1 keeps 255.
- Wrap: same setup with saturate_p=0 -> 250+15 gives 9, ovf=1. Snapshot -> data 9, ovf_o=1.
- Clear-on-snap boundary: channel 1 counts inc=2 every cycle. Snapshot with clear=1 after 4 cycles -> shadow 8; the live counter restarts at 2 (no lost event); live_ovf cleared.
- Backpressure and mid-drain reset: hold yumi low for 5 cycles -> v_o, data_o and id_o stable. Assert reset at idx=4 -> next cycle v_o=0, snap_ready_o=0; after reset snap_ready_o=1 and all counts 0.
- SKIP_ZERO_EN: only channels 2 and 6 nonzero -> exactly two beats, id 2 then id 6, then IDLE. All-zero snapshot -> no v_o; snap_ready_o returns 2 cycles after acceptance.
